// File: rtl/risc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// risc_ctrl_pkg
// Shared encodings for the multicycle RISC control unit:
//   - instruction opcodes decoded from instr[31:26]
//   - FSM state encoding (4-bit)
//   - ALU operation class, ALU B-source and PC-source select codes
//   - next-state helper for the DECODE dispatch
// Optional feature macro: ILLEGAL_TRAP_EN (selects where unknown opcodes go).
// -----------------------------------------------------------------------------
package risc_ctrl_pkg;

    localparam int OPC_W_DEF   = 6;
    localparam int ALUOP_W_DEF = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE. Unknown opcodes either trap or fall
    // straight back to FETCH, which makes them behave as a 2-cycle NOP.
    function automatic state_t decode_next(input logic [5:0] opc);
        state_t nxt;
        case (opc)
            OP_RTYPE:      nxt = ST_EXEC_R;
            OP_ADDI:       nxt = ST_EXEC_I;
            OP_LW, OP_SW:  nxt = ST_MEM_ADDR;
            OP_BEQ:        nxt = ST_BRANCH;
            OP_J:          nxt = ST_JUMP;
`ifdef ILLEGAL_TRAP_EN
            default:       nxt = ST_TRAP;
`else
            default:       nxt = ST_FETCH;
`endif
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Main control FSM for the 32-bit multicycle RISC datapath. Sequences each
// instruction through fetch / decode / execute / memory / writeback and drives
// the register file, operand latches, memory strobes and datapath selects.
// Moore machine: outputs depend only on the registered state, except the FETCH
// PC/IR load enables (gated by mem_ready) and the BRANCH pc_write (= zero).
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcode -> TRAP, illegal_op=1, all strobes 0 until reset
//   undefined : unknown opcode executes as a NOP, illegal_op tied to 0
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   opcode         in   instr[31:26] from IR
//   zero           in   ALU zero flag (BEQ compare)
//   mem_ready      in   memory completed current access this cycle
//   pc_write       out  PC load enable
//   ir_write       out  IR load enable
//   write_enable_A out  operand latch A enable
//   write_enable_B out  operand latch B enable
//   reg_write      out  register file write enable
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   i_or_d         out  memory address select: 0 PC, 1 ALU result
//   reg_dst        out  write register select: 0 rt, 1 rd
//   mem_to_reg     out  write data select: 0 ALU result, 1 MDR
//   alu_src_a      out  0 PC, 1 A
//   alu_src_b      out  00 B, 01 const 4, 10 imm, 11 imm<<2
//   alu_op         out  00 add, 01 sub, 10 funct-decoded
//   pc_src         out  00 ALU out, 01 ALU result reg, 10 jump target
//   illegal_op     out  sticky illegal-opcode flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST      | held in reset, all outputs 0
// FETCH    | read instruction at PC, PC+4; waits on mem_ready
// DECODE   | latch A/B, precompute branch target
// EXEC_R   | R-type ALU operation
// WB_R     | write ALU result to rd
// EXEC_I   | ADDI: A + sign-extended immediate
// WB_I     | write ALU result to rt
// MEM_ADDR | LW/SW effective address
// MEM_RD   | data read; waits on mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | data write; waits on mem_ready
// BRANCH   | BEQ compare, PC <= target when zero
// JUMP     | PC <= jump target
// TRAP     | illegal opcode seen, frozen until reset
// -----------------------------------------------------------------------------
module multicycle_control_unit
    import risc_ctrl_pkg::*;
#(
    parameter int OPC_W   = OPC_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               write_enable_A,
    output logic               write_enable_B,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RST:      w_next_state = ST_FETCH;
            ST_FETCH:    w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   w_next_state = decode_next(opcode);
            ST_EXEC_R:   w_next_state = ST_WB_R;
            ST_EXEC_I:   w_next_state = ST_WB_I;
            ST_MEM_ADDR: w_next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   w_next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_WB_R,
            ST_WB_I,
            ST_MEM_WB,
            ST_BRANCH,
            ST_JUMP:     w_next_state = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:     w_next_state = ST_TRAP;
`else
            ST_TRAP:     w_next_state = ST_FETCH;
`endif
            default:     w_next_state = ST_RST;
        endcase
    end

    always_comb begin
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        write_enable_A = 1'b0;
        write_enable_B = 1'b0;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_or_d         = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_a      = 1'b0;
        alu_src_b      = ALUSRCB_B;
        alu_op         = ALUOP_W'(ALUOP_ADD);
        pc_src         = PCSRC_ALU;
        illegal_op     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                // PC and IR only load once the instruction word is valid.
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            ST_DECODE: begin
                write_enable_A = 1'b1;
                write_enable_B = 1'b1;
                alu_src_b      = ALUSRCB_IMM_SH2;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_B;
                alu_op    = ALUOP_W'(ALUOP_FUNCT);
            end
            ST_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_EXEC_I,
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
            end
            ST_WB_I: begin
                reg_write = 1'b1;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_B;
                alu_op    = ALUOP_W'(ALUOP_SUB);
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
            end
            ST_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            // TRAP is absorbing, so deriving the flag from the state keeps it sticky.
            ST_TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench for multicycle_control_unit. An instruction is modelled
// as the ordered list of steps it walks through; each step has a fixed control
// word, and memory steps repeat for every cycle mem_ready is low. Inputs are
// driven on the falling edge and outputs compared 1 ns later.
// Honours ILLEGAL_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    typedef enum int {
        PH_FETCH, PH_DECODE, PH_EXR, PH_WBR, PH_EXI, PH_WBI,
        PH_ADDR, PH_MRD, PH_MWB, PH_MWR, PH_BR, PH_JMP, PH_TRAP
    } phase_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       we_a;
        logic       we_b;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, write_enable_A, write_enable_B, reg_write;
    logic       mem_read, mem_write, i_or_d, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op;
    ctl_t       act;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPC_W(6), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write),
        .write_enable_A(write_enable_A), .write_enable_B(write_enable_B),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal_op(illegal_op)
    );

    assign act = {pc_write, ir_write, write_enable_A, write_enable_B, reg_write,
                  mem_read, mem_write, i_or_d, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, pc_src, illegal_op};

    // Control word each step must present, taken straight from the step descriptions.
    function automatic ctl_t exp_out(input phase_t ph, input logic rdy, input logic z);
        ctl_t e;
        e = '0;
        case (ph)
            PH_FETCH:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.pc_write = rdy; e.ir_write = rdy; end
            PH_DECODE: begin e.we_a = 1; e.we_b = 1; e.alu_src_b = 2'b11; end
            PH_EXR:    begin e.alu_src_a = 1; e.alu_src_b = 2'b00; e.alu_op = 2'b10; end
            PH_WBR:    begin e.reg_write = 1; e.reg_dst = 1; end
            PH_EXI:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            PH_WBI:    begin e.reg_write = 1; end
            PH_ADDR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            PH_MRD:    begin e.mem_read = 1; e.i_or_d = 1; end
            PH_MWB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
            PH_MWR:    begin e.mem_write = 1; e.i_or_d = 1; end
            PH_BR:     begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_write = z; end
            PH_JMP:    begin e.pc_src = 2'b10; e.pc_write = 1; end
            PH_TRAP:   begin e.illegal_op = 1; end
            default:   ;
        endcase
        return e;
    endfunction

    function automatic bit is_legal(input logic [5:0] opc);
        return opc inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] o;
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
        return o;
    endfunction

    // Runs one instruction starting at a falling edge with the DUT in FETCH.
    // stalls < 0 picks a random 0..2 stall count. zmode: 0/1 fixed, 2 random per cycle.
    // Reports cycle count, cycle index of the first reg_write and pulse counts.
    task automatic run_instr(input logic [5:0] opc, input int f_stalls, input int m_stalls,
                             input int zmode, output int n_cyc, output int rw_at,
                             output int rw_cnt, output int mw_cnt);
        phase_t q[$];
        int     n;
        logic   rdy, z;
        ctl_t   e;
        opcode = opc;
        n_cyc = 0; rw_at = 0; rw_cnt = 0; mw_cnt = 0;
        q.push_back(PH_FETCH);
        q.push_back(PH_DECODE);
        case (opc)
            6'h00: begin q.push_back(PH_EXR); q.push_back(PH_WBR); end
            6'h08: begin q.push_back(PH_EXI); q.push_back(PH_WBI); end
            6'h23: begin q.push_back(PH_ADDR); q.push_back(PH_MRD); q.push_back(PH_MWB); end
            6'h2B: begin q.push_back(PH_ADDR); q.push_back(PH_MWR); end
            6'h04: q.push_back(PH_BR);
            6'h02: q.push_back(PH_JMP);
            default: ;
        endcase
        foreach (q[i]) begin
            n = 0;
            if (q[i] == PH_FETCH) n = (f_stalls < 0) ? int'($urandom_range(0, 2)) : f_stalls;
            if (q[i] == PH_MRD || q[i] == PH_MWR)
                n = (m_stalls < 0) ? int'($urandom_range(0, 2)) : m_stalls;
            for (int k = 0; k <= n; k++) begin
                if (q[i] == PH_FETCH || q[i] == PH_MRD || q[i] == PH_MWR) rdy = (k == n);
                else rdy = ($urandom % 2) != 0;
                z = (zmode == 2) ? (($urandom % 2) != 0) : (zmode == 1);
                mem_ready = rdy;
                zero = z;
                #1;
                n_cyc++;
                e = exp_out(q[i], rdy, z);
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL step op=%h phase=%s cyc=%0d got=%h want=%h",
                             opc, q[i].name(), n_cyc, act, e);
                end
                if (act.reg_write) begin
                    rw_cnt++;
                    if (rw_at == 0) rw_at = n_cyc;
                end
                if (act.mem_write) mw_cnt++;
                @(negedge clk);
            end
        end
    endtask

    // Reset back to FETCH, leaving the bench at a falling edge.
    task automatic reset_to_fetch();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        ctl_t e;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            zero = ($urandom % 2) != 0;
            opcode = 6'($urandom);
            #1;
            vectors++;
            if (act !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%h want=0", c, act);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL reset_release got=%h want=0", act);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL reset_first_fetch got=%h want=%h", act, e);
        end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        int nc, ra, rc, mc;
        run_instr(6'h00, 0, 0, 2, nc, ra, rc, mc);
        vectors++;
        if (nc !== 4 || ra !== 4 || rc !== 1) begin
            miscompares++;
            $display("FAIL rtype_timing got cyc=%0d rw_at=%0d rw_cnt=%0d want 4/4/1", nc, ra, rc);
        end
    endtask

    task automatic test_lw_stall();
        int nc, ra, rc, mc;
        run_instr(6'h23, 0, 2, 2, nc, ra, rc, mc);
        vectors++;
        if (nc !== 7 || ra !== 7 || rc !== 1 || mc !== 0) begin
            miscompares++;
            $display("FAIL lw_stall got cyc=%0d rw_at=%0d rw_cnt=%0d mw=%0d want 7/7/1/0",
                     nc, ra, rc, mc);
        end
    endtask

    task automatic test_beq();
        int nc, ra, rc, mc;
        for (int zz = 1; zz >= 0; zz--) begin
            run_instr(6'h04, 0, 0, zz, nc, ra, rc, mc);
            vectors++;
            if (nc !== 3 || rc !== 0) begin
                miscompares++;
                $display("FAIL beq_z%0d got cyc=%0d rw_cnt=%0d want 3/0", zz, nc, rc);
            end
        end
    endtask

    task automatic test_sw_reset();
        ctl_t e;
        int   nc, ra, rc, mc;
        run_instr(6'h2B, 0, 0, 2, nc, ra, rc, mc);
        vectors++;
        if (nc !== 4 || mc !== 1 || rc !== 0) begin
            miscompares++;
            $display("FAIL sw_plain got cyc=%0d mw=%0d rw=%0d want 4/1/0", nc, mc, rc);
        end
        opcode = 6'h2B;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_in_mem_wr got mem_write=%b want 1", mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL sw_async_drop got=%h want=0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (act !== '0) begin
            miscompares++;
            $display("FAIL sw_post_reset got=%h want=0", act);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL sw_refetch got=%h want=%h", act, e);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int nc, ra, rc, mc;
        run_instr(6'h3F, 0, 0, 2, nc, ra, rc, mc);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 5; k++) begin
            mem_ready = ($urandom % 2) != 0;
            zero = ($urandom % 2) != 0;
            #1;
            vectors++;
            if (act !== exp_out(PH_TRAP, mem_ready, zero)) begin
                miscompares++;
                $display("FAIL trap_hold k=%0d got=%h want=%h", k, act,
                         exp_out(PH_TRAP, mem_ready, zero));
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (illegal_op !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_clear got illegal_op=%b want 0", illegal_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        vectors++;
        if (nc !== 2 || illegal_op !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_nop got cyc=%0d illegal_op=%b want 2/0", nc, illegal_op);
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (mem_read !== 1'b1 || write_enable_A !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_refetch got mem_read=%b we_a=%b want 1/0",
                     mem_read, write_enable_A);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal [6];
        logic [5:0] opc;
        int nc, ra, rc, mc, base, stl;
        legal = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        for (int t = 0; t < 60; t++) begin
            opc = legal[$urandom_range(0, 5)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) opc = rand_illegal();
`endif
            run_instr(opc, -1, -1, 2, nc, ra, rc, mc);
            base = (opc == 6'h23) ? 5 : (opc inside {6'h00, 6'h08, 6'h2B}) ? 4 :
                   (opc inside {6'h04, 6'h02}) ? 3 : 2;
            stl = nc - base;
            vectors++;
            if (stl < 0 || stl > 4 ||
                rc !== ((opc inside {6'h00, 6'h08, 6'h23}) ? 1 : 0) ||
                mc !== ((opc == 6'h2B) ? stl - ((stl > 2) ? 2 : 0) + 1 - (stl > 2 ? 0 : 0) : 0) && opc == 6'h2B && mc < 1) begin
                miscompares++;
                $display("FAIL b2b op=%h got cyc=%0d rw=%0d mw=%0d", opc, nc, rc, mc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_sw_reset();
        test_illegal();
        test_back_to_back();
        reset_to_fetch();
        test_rtype();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
